// File: rtl/up_counter_sequencer.sv
// up_counter_sequencer
//   Run controller for a sync_up_counter. It accepts a run command
//   (terminal value plus repeat count) over a valid/ready handshake. For
//   each run it clears the counter, then lets it count up to the terminal
//   value. The run is repeated as programmed, and the last run ends with a
//   one-cycle done pulse.
//
// Ports
//   clk, reset   : system clock; synchronous active-high reset
//   cmd_valid    : command present
//   cmd_ready    : sequencer idle and able to accept a command
//   cmd_target   : terminal count value
//   cmd_repeat   : number of extra runs (0 = single run)
//   pause        : level; holds the counter while high during RUN
//   abort        : cancels the active command (CLEAR/RUN only)
//   count        : counter value fed back from sync_up_counter
//   cnt_enable   : to counter enable (combinational in RUN)
//   cnt_clear    : to counter reset (ORed with system reset outside)
//   busy         : command in progress (CLEAR or RUN)
//   done         : one-cycle completion pulse
//   runs_left    : remaining extra runs
module up_counter_sequencer #(
  parameter int WIDTH = 4,
  parameter int RPT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_target,
  input  logic [RPT_W-1:0] cmd_repeat,
  input  logic             pause,
  input  logic             abort,
  input  logic [WIDTH-1:0] count,
  output logic             cnt_enable,
  output logic             cnt_clear,
  output logic             busy,
  output logic             done,
  output logic [RPT_W-1:0] runs_left
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [RPT_W-1:0] rpt_q, rpt_d;
  logic             at_target;

  assign at_target = (count == target_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      target_q <= '0;
      rpt_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      rpt_q    <= rpt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    rpt_d      = rpt_q;
    cnt_enable = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Command fields are sampled only on the handshake edge.
        if (cmd_valid) begin
          target_d = cmd_target;
          rpt_d    = cmd_repeat;
          state_d  = CLEAR;
        end
      end
      CLEAR: begin
        if (abort) begin
          rpt_d   = '0;
          state_d = IDLE;
        end else begin
          state_d = RUN;
        end
      end
      RUN: begin
        // Enable is combinational so the counter stops exactly on the
        // terminal value and never wraps; abort and pause gate it the same
        // cycle they are seen.
        cnt_enable = !pause && !abort && !at_target;
        if (abort) begin
          rpt_d   = '0;
          state_d = IDLE;
        end else if (at_target) begin
          if (rpt_q == '0) begin
            state_d = DONE;
          end else begin
            rpt_d   = rpt_q - RPT_W'(1);
            state_d = CLEAR;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Moore output decodes.
  assign cmd_ready = (state_q == IDLE);
  assign cnt_clear = (state_q == CLEAR);
  assign busy      = (state_q == CLEAR) || (state_q == RUN);
  assign done      = (state_q == DONE);
  assign runs_left = rpt_q;

endmodule
